// File: rtl/instruction_fetch.sv
// instruction_fetch: single-stage instruction fetch with a one-word skid buffer.
//   FETCH keeps a read request outstanding at mem_addr=pc. HOLD parks a returned
//   word in the skid register while the decoder is stalled and issues no request.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall               downstream cannot accept; IF/ID registers hold
//   flush               replace IF/ID contents with a bubble
//   branch_taken/target redirect the PC; dominates all other inputs
//   mem_req/mem_addr    instruction-memory read request and word address (= pc)
//   mem_ready/mem_rdata read completion and returned word
//   instruction/pc_out  IF/ID register: fetched word and its address+1
//   valid               instruction holds a real word (0 = bubble)
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instruction,
  output logic [15:0] pc_out,
  output logic        valid
);

  localparam int unsigned W = 16;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   pc, pc_nxt;
  logic [W-1:0]   pc_inc;
  logic [W-1:0]   skid, skid_nxt;
  logic [W-1:0]   instr_nxt;
  logic [W-1:0]   pc_out_nxt;
  logic           valid_nxt;

  // Modulo-2^16 increment; wraps FFFF -> 0000.
  assign pc_inc = pc + W'(1);

  // Request is abandoned combinationally while reset is asserted.
  assign mem_req  = (state == FETCH) && !rst;
  assign mem_addr = pc;

  // State and register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      skid        <= NOP_WORD;
      instruction <= NOP_WORD;
      pc_out      <= W'(0);
      valid       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      skid        <= skid_nxt;
      instruction <= instr_nxt;
      pc_out      <= pc_out_nxt;
      valid       <= valid_nxt;
    end
  end

  // Next-state and IF/ID update rules.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    skid_nxt   = skid;
    instr_nxt  = instruction;
    pc_out_nxt = pc_out;
    valid_nxt  = valid;

    if (branch_taken) begin
      // Redirect: drop any returning word and the skid contents.
      pc_nxt    = branch_target;
      instr_nxt = NOP_WORD;
      valid_nxt = 1'b0;
      skid_nxt  = NOP_WORD;
      state_nxt = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            if (stall || flush) begin
              // IF/ID cannot take the word this cycle; park it so it is not lost.
              skid_nxt  = mem_rdata;
              state_nxt = HOLD;
              if (flush) begin
                instr_nxt = NOP_WORD;
                valid_nxt = 1'b0;
              end
            end else begin
              instr_nxt  = mem_rdata;
              pc_out_nxt = pc_inc;
              valid_nxt  = 1'b1;
              pc_nxt     = pc_inc;
            end
          end else if (flush || !stall) begin
            instr_nxt = NOP_WORD;
            valid_nxt = 1'b0;
          end
        end
        HOLD: begin
          if (!stall && !flush) begin
            instr_nxt  = skid;
            pc_out_nxt = pc_inc;
            valid_nxt  = 1'b1;
            pc_nxt     = pc_inc;
            state_nxt  = FETCH;
          end else if (flush) begin
            // Bubble IF/ID but keep the skid word for later delivery.
            instr_nxt = NOP_WORD;
            valid_nxt = 1'b0;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, a
// mid-request asynchronous reset sequence, then randomized traffic against a
// stream-level reference model.
module tb_instruction_fetch;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, branch_taken, mem_ready;
  logic [15:0] branch_target;
  logic        mem_req;
  logic [15:0] mem_addr, mem_rdata, instruction, pc_out;
  logic        valid;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  // Memory image: word at address a is 4000+a.
  assign mem_rdata = 16'h4000 + mem_addr;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .valid        (valid)
  );

  typedef struct {
    logic        rst, stall, flush, br;
    logic [15:0] tgt;
    logic        ready;
    logic        req;
    logic [15:0] addr, instr, pcout;
    logic        vld;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic s, logic f, logic b, logic [15:0] t,
                              logic rd, logic q, logic [15:0] a, logic [15:0] i,
                              logic [15:0] p, logic v);
    vec_t x;
    x.rst = r; x.stall = s; x.flush = f; x.br = b; x.tgt = t; x.ready = rd;
    x.req = q; x.addr = a; x.instr = i; x.pcout = p; x.vld = v;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic q, input logic [15:0] a,
                         input logic [15:0] i, input logic [15:0] p, input logic v);
    chk("mem_req", idx, 16'(mem_req), 16'(q));
    if (q) chk("mem_addr", idx, mem_addr, a);
    chk("instruction", idx, instruction, i);
    chk("pc_out", idx, pc_out, p);
    chk("valid", idx, 16'(valid), 16'(v));
  endtask

  // Reference model: next address, at most one parked word, and the IF/ID view.
  logic [15:0] m_pc, m_instr, m_pcout;
  logic        m_valid;
  logic [15:0] m_park[$];

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = NOP; m_pcout = 16'h0000; m_valid = 1'b0;
    m_park.delete();
  endtask

  task automatic model_step(input logic s, input logic f, input logic b,
                            input logic [15:0] t, input logic rd);
    logic        waiting;
    logic [15:0] w;
    waiting = (m_park.size() != 0);
    if (b) begin
      m_pc = t; m_instr = NOP; m_valid = 1'b0; m_park.delete();
    end else if (!waiting && rd) begin
      w = 16'h4000 + m_pc;
      if (!s && !f) begin
        m_instr = w; m_pcout = m_pc + 16'd1; m_valid = 1'b1; m_pc = m_pc + 16'd1;
      end else begin
        m_park.push_back(w);
        if (f) begin m_instr = NOP; m_valid = 1'b0; end
      end
    end else if (waiting && !s && !f) begin
      m_instr = m_park.pop_front(); m_pcout = m_pc + 16'd1; m_valid = 1'b1;
      m_pc = m_pc + 16'd1;
    end else if (f || !s) begin
      m_instr = NOP; m_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    branch_target = 16'h0000; mem_ready = 1'b0;

    //           rst s  f  br tgt       rdy req addr      instr     pcout     v
    vt.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, NOP,      16'h0000, 0));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0001, 16'h4000, 16'h0001, 1));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0002, 16'h4001, 16'h0002, 1));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0003, 16'h4002, 16'h0003, 1));
    vt.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 0, 16'h0003, 16'h4002, 16'h0003, 1));
    vt.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 0, 16'h0003, 16'h4002, 16'h0003, 1));
    vt.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 0, 16'h0003, 16'h4002, 16'h0003, 1));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h4003, 16'h0004, 1));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0005, 16'h4004, 16'h0005, 1));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0005, NOP,      16'h0005, 0));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0005, NOP,      16'h0005, 0));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0006, 16'h4005, 16'h0006, 1));
    vt.push_back(mk(0, 1, 0, 1, 16'h0100, 1, 1, 16'h0100, NOP,      16'h0006, 0));
    vt.push_back(mk(0, 0, 0, 1, 16'hFFFF, 0, 1, 16'hFFFF, NOP,      16'h0006, 0));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h3FFF, 16'h0000, 1));
    vt.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 1, 16'h0000, NOP,      16'h0000, 0));
    vt.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, NOP,      16'h0000, 0));
    vt.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 0, 16'h0000, NOP,      16'h0000, 0));
    vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0001, 16'h4000, 16'h0001, 1));

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      rst = vt[i].rst; stall = vt[i].stall; flush = vt[i].flush;
      branch_taken = vt[i].br; branch_target = vt[i].tgt; mem_ready = vt[i].ready;
      @(posedge clk);
      #1;
      chk_all(i, vt[i].req, vt[i].addr, vt[i].instr, vt[i].pcout, vt[i].vld);
    end

    // Asynchronous reset while a request at address 9 is waiting.
    @(negedge clk);
    stall = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 16'h0009;
    @(negedge clk);
    branch_taken = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_addr", 100, mem_addr, 16'h0009);
    chk("pre_rst_req", 100, 16'(mem_req), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all(101, 1'b0, 16'h0000, NOP, 16'h0000, 1'b0);
    chk("rst_pc", 101, mem_addr, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all(102, 1'b1, 16'h0000, NOP, 16'h0000, 1'b0);

    // Randomized traffic against the reference model.
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic s, f, b, rd;
      logic [15:0] t;
      @(negedge clk);
      chk_all(1000 + c, (m_park.size() == 0), m_pc, m_instr, m_pcout, m_valid);
      s  = ($urandom_range(0, 99) < 30);
      f  = ($urandom_range(0, 99) < 10);
      b  = ($urandom_range(0, 99) < 5);
      rd = ($urandom_range(0, 99) < 65);
      t  = ($urandom_range(0, 9) == 0) ? 16'hFFFE : 16'($urandom);
      stall = s; flush = f; branch_taken = b; branch_target = t; mem_ready = rd;
      model_step(s, f, b, t, rd);
      @(posedge clk);
    end
    @(negedge clk);
    chk_all(9999, (m_park.size() == 0), m_pc, m_instr, m_pcout, m_valid);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
